md_scheduler: RTL and testbench

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_scheduler_if.sv | 30 +++
 rtl/md_scheduler.sv | 112 +++++++++++
 tb/tb_md_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_scheduler_if.sv
// Pipeline-facing bundle of the multiply/divide scheduler: EX-stage launch,
// HI/LO moves and the status/result signals returned to the pipeline.
interface md_scheduler_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        rd_req;
    logic        rd_sel;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata, rd_req, rd_sel, flush,
        input  busy, stall, done, hi, lo, rd_data
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata, rd_req, rd_sel, flush,
        output busy, stall, done, hi, lo, rd_data
    );
endinterface

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: launches mult/div from EX, counts out a fixed
// latency, then commits the result to the architectural HI/LO pair.
module md_scheduler #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_scheduler_if.slave md
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r, hi_r, lo_r;
    logic        accept, commit;

    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic        sgn, a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem, res_hi, res_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (md.flush || cnt <= 4'd1) state_next = IDLE;
        endcase
    end

    // A flush on the final count cancels the commit as well as the operation.
    always_comb begin
        accept     = (state == IDLE) && md.start && !md.flush;
        commit     = (state == RUN) && (cnt == 4'd1) && !md.flush;
        md.busy    = (state == RUN);
        md.done    = commit;
        md.stall   = ((state == RUN) || accept)
                     && (md.start || md.wr_hi || md.wr_lo || md.rd_req)
                     && !md.flush;
        md.hi      = hi_r;
        md.lo      = lo_r;
        md.rd_data = md.rd_sel ? hi_r : lo_r;
    end

    // Signed divide works on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
    always_comb begin
        a_sx     = {{32{a_r[31]}}, a_r};
        b_sx     = {{32{b_r[31]}}, b_r};
        prod_s   = a_sx * b_sx;
        prod_u   = {32'd0, a_r} * {32'd0, b_r};
        sgn      = ~op_r[0];
        a_neg    = sgn & a_r[31];
        b_neg    = sgn & b_r[31];
        a_mag    = a_neg ? (32'd0 - a_r) : a_r;
        b_mag    = b_neg ? (32'd0 - b_r) : b_r;
        div_zero = (b_r == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
        if (op_r[1]) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = op_r[0] ? prod_u[63:32] : prod_s[63:32];
            res_lo = op_r[0] ? prod_u[31:0]  : prod_s[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_r <= '0;
            a_r  <= '0;
            b_r  <= '0;
        end else if (accept) begin
            op_r <= md.op;
            a_r  <= md.a;
            b_r  <= md.b;
            cnt  <= md.op[1] ? DIV_LOAD : MULT_LOAD;
        end else if (state == RUN) begin
            cnt  <= md.flush ? 4'd0 : cnt - 4'd1;
        end
    end

    // A launch in IDLE takes priority over mthi/mtlo in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (commit) begin
            if (!(op_r[1] && div_zero)) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
            end
        end else if ((state == IDLE) && !md.start && !md.flush) begin
            if (md.wr_hi) hi_r <= md.wdata;
            if (md.wr_lo) lo_r <= md.wdata;
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed corner cases plus randomised
// traffic compared every cycle against a timeline-based reference model.
module tb_md_scheduler;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    md_scheduler_if bus();

    md_scheduler #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic wr_hi, input logic wr_lo,
                                 input logic [31:0] wdata, input logic rd_req, input logic rd_sel,
                                 input logic flush);
        bus.start  = start;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        bus.wr_hi  = wr_hi;
        bus.wr_lo  = wr_lo;
        bus.wdata  = wdata;
        bus.rd_req = rd_req;
        bus.rd_sel = rd_sel;
        bus.flush  = flush;
    endtask

    task automatic stepDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIdle();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idleCycle();
        stepDrive();
        driveIdle();
        @(negedge clk);
    endtask

    // Reference model: an accepted launch commits exactly LAT cycles later
    // unless flushed or reset; results come from plain integer arithmetic.
    bit          m_pend   = 1'b0;
    bit          m_wr     = 1'b0;
    longint      m_commit = 0;
    longint      cyc      = 0;
    logic [31:0] m_nhi = '0, m_nlo = '0, m_hi = '0, m_lo = '0;

    function automatic void mdResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output bit wr, output logic [31:0] rhi, output logic [31:0] rlo);
        longint p;
        int     sa, sb;
        wr  = 1'b1;
        rhi = '0;
        rlo = '0;
        sa  = a;
        sb  = b;
        case (op)
            2'b00: begin
                p   = longint'(sa) * longint'(sb);
                rhi = p[63:32];
                rlo = p[31:0];
            end
            2'b01: begin
                p   = {32'd0, a} * {32'd0, b};
                rhi = p[63:32];
                rlo = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) wr = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rhi = 32'd0;
                    rlo = 32'h8000_0000;
                end else begin
                    rlo = sa / sb;
                    rhi = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    rlo = a / b;
                    rhi = a % b;
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        logic accept, exp_done, exp_stall;
        if (reset) begin
            m_pend = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end
        accept    = !m_pend && bus.start && !bus.flush;
        exp_done  = m_pend && (cyc == m_commit) && !bus.flush;
        exp_stall = (m_pend || accept) && (bus.start || bus.wr_hi || bus.wr_lo || bus.rd_req) && !bus.flush;
        checkBit("model_busy", bus.busy, m_pend);
        checkBit("model_done", bus.done, exp_done);
        checkBit("model_stall", bus.stall, exp_stall);
        checkOutput("model_hi", bus.hi, m_hi);
        checkOutput("model_lo", bus.lo, m_lo);
        checkOutput("model_rd_data", bus.rd_data, bus.rd_sel ? m_hi : m_lo);
        if (!reset) begin
            if (m_pend) begin
                if (bus.flush) m_pend = 1'b0;
                else if (cyc == m_commit) begin
                    if (m_wr) begin
                        m_hi = m_nhi;
                        m_lo = m_nlo;
                    end
                    m_pend = 1'b0;
                end
            end else if (!bus.flush) begin
                if (bus.start) begin
                    m_pend   = 1'b1;
                    m_commit = cyc + (bus.op[1] ? DIV_CYC : MULT_CYC);
                    mdResult(bus.op, bus.a, bus.b, m_wr, m_nhi, m_nlo);
                end else begin
                    if (bus.wr_hi) m_hi = bus.wdata;
                    if (bus.wr_lo) m_lo = bus.wdata;
                end
            end
        end
        cyc++;
    end

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        stepDrive();
        applyStimulus(1'b1, op, a, b, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkBit("launch_stall", bus.stall, 1'b1);
    endtask

    task automatic waitDone(input logic rd, output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            stepDrive();
            applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, rd && (k >= 2), 1'b0, 1'b0);
            @(negedge clk);
            if (rd && (k >= 2)) checkBit("rd_stall", bus.stall, 1'b1);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        launch(op, a, b);
        waitDone(1'b0, lat);
        checkOutput("latency", lat, exp_lat);
        idleCycle();
        checkBit("op_busy_after", bus.busy, 1'b0);
        checkOutput("op_hi", bus.hi, exp_hi);
        checkOutput("op_lo", bus.lo, exp_lo);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int lat, pulses;
        driveIdle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkBit("rst_busy", bus.busy, 1'b0);
        checkBit("rst_done", bus.done, 1'b0);
        checkBit("rst_stall", bus.stall, 1'b0);
        checkOutput("rst_hi", bus.hi, 32'd0);
        checkOutput("rst_lo", bus.lo, 32'd0);
        stepDrive();
        reset = 1'b0;

        // mthi / mtlo, and flush suppressing a write
        stepDrive();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkBit("wr_stall", bus.stall, 1'b0);
        stepDrive();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wr_hi", bus.hi, 32'h1234_5678);
        stepDrive();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("wr_lo", bus.lo, 32'h0BAD_F00D);
        idleCycle();
        checkOutput("flush_wr_hi", bus.hi, 32'h1234_5678);

        // arithmetic and latency
        runOp(2'b00, 32'hFFFF_FFFE, 32'd3, MULT_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runOp(2'b01, 32'hFFFF_FFFE, 32'd3, MULT_CYC, 32'h0000_0002, 32'hFFFF_FFFA);
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp(2'b11, 32'd7, 32'd0, DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYC, 32'd0, 32'h8000_0000);

        // mfhi/mflo while busy
        launch(2'b00, 32'd1000, 32'd1000);
        waitDone(1'b1, lat);
        checkOutput("rd_latency", lat, MULT_CYC);
        stepDrive();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkBit("rd_stall_released", bus.stall, 1'b0);
        checkOutput("rd_data_new_lo", bus.rd_data, 32'h000F_4240);

        // flush of a divide in flight, then immediate relaunch
        launch(2'b10, 32'd100, 32'd7);
        repeat (3) idleCycle();
        stepDrive();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkBit("flush_done", bus.done, 1'b0);
        launch(2'b10, 32'd9, 32'd4);
        checkBit("flush_busy", bus.busy, 1'b0);
        checkOutput("flush_hi", bus.hi, 32'd0);
        checkOutput("flush_lo", bus.lo, 32'h000F_4240);
        waitDone(1'b0, lat);
        checkOutput("relaunch_latency", lat, DIV_CYC);
        idleCycle();
        checkOutput("relaunch_hi", bus.hi, 32'd1);
        checkOutput("relaunch_lo", bus.lo, 32'd2);

        // flush on the commit cycle
        launch(2'b01, 32'd5, 32'd6);
        repeat (4) idleCycle();
        stepDrive();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkBit("commit_flush_done", bus.done, 1'b0);
        idleCycle();
        checkBit("commit_flush_busy", bus.busy, 1'b0);
        checkOutput("commit_flush_hi", bus.hi, 32'd1);
        checkOutput("commit_flush_lo", bus.lo, 32'd2);

        // back-to-back launch in the cycle after done
        launch(2'b00, 32'd3, 32'd4);
        waitDone(1'b0, lat);
        checkOutput("b2b_first_latency", lat, MULT_CYC);
        launch(2'b01, 32'd5, 32'd6);
        waitDone(1'b0, lat);
        checkOutput("b2b_second_latency", lat, MULT_CYC);
        idleCycle();
        checkOutput("b2b_hi", bus.hi, 32'd0);
        checkOutput("b2b_lo", bus.lo, 32'd30);

        // asynchronous reset in the middle of an operation
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (2) idleCycle();
        checkBit("pre_reset_busy", bus.busy, 1'b1);
        stepDrive();
        driveIdle();
        reset = 1'b1;
        #1;
        checkBit("async_rst_busy", bus.busy, 1'b0);
        checkBit("async_rst_done", bus.done, 1'b0);
        checkOutput("async_rst_hi", bus.hi, 32'd0);
        checkOutput("async_rst_lo", bus.lo, 32'd0);
        stepDrive();
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        checkOutput("post_reset_done_pulses", pulses, 0);

        // randomised traffic, checked by the model every cycle
        for (int i = 0; i < 800; i++) begin
            stepDrive();
            reset = ($urandom_range(0, 249) == 0);
            applyStimulus($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), randOperand(), randOperand(),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom(),
                          $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
        end
        stepDrive();
        reset = 1'b0;
        driveIdle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
